// File: rtl/shift_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined shift unit.
package shift_pkg;

  localparam logic [1:0] MODE_SHL = 2'b00;
  localparam logic [1:0] MODE_SHR = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  // Smallest r with 2**r >= n.
  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // First mux level owned by stage s; stage s covers [lo(s), lo(s+1)).
  function automatic int stage_level_lo(input int s, input int log2n, input int stages);
    return (s * log2n) / stages;
  endfunction

endpackage

// File: rtl/shift_unit_pipe_if.sv
// Token interface of the shift operator node: two operand channels in, one result out.
interface shift_unit_pipe_if #(
  parameter int N = 16
);
  logic         R_IN1;
  logic [N-1:0] D_IN1;
  logic         R_IN2;
  logic [N-1:0] D_IN2;
  logic [1:0]   MODE;
  logic         R_OUT;
  logic [N-1:0] D_OUT;
  logic         OVR_OUT;

  modport master (
    output R_IN1, D_IN1, R_IN2, D_IN2, MODE,
    input  R_OUT, D_OUT, OVR_OUT
  );

  modport slave (
    input  R_IN1, D_IN1, R_IN2, D_IN2, MODE,
    output R_OUT, D_OUT, OVR_OUT
  );
endinterface

// File: rtl/shift_stage.sv
// One pipeline stage: a slice of the log-shifter mux levels followed by the payload register.
// SHL travels bit-reversed through the right-shift datapath; the first stage reverses on
// entry and the last stage reverses back and applies the out-of-range result.
module shift_stage
  import shift_pkg::*;
#(
  parameter int N     = 16,
  parameter int LOG2N = 4,
  parameter int FIRST = 0,
  parameter int COUNT = 1,
  parameter bit LAST  = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             valid_i,
  input  logic [N-1:0]     data_i,
  input  logic [LOG2N-1:0] amt_i,
  input  logic [1:0]       mode_i,
  input  logic             fill_i,
  input  logic             big_i,
  output logic             valid_o,
  output logic [N-1:0]     data_o,
  output logic [LOG2N-1:0] amt_o,
  output logic [1:0]       mode_o,
  output logic             fill_o,
  output logic             big_o
);

  logic [N-1:0]     data_d;
  logic             valid_q;
  logic [N-1:0]     data_q;
  logic [LOG2N-1:0] amt_q;
  logic [1:0]       mode_q;
  logic             fill_q;
  logic             big_q;

  function automatic logic [N-1:0] shr_fill(input logic [N-1:0] v, input int k, input logic f);
    logic [N-1:0] fmask;
    fmask = ~({N{1'b1}} >> k);
    return (v >> k) | (f ? fmask : '0);
  endfunction

  function automatic logic [N-1:0] rot_r(input logic [N-1:0] v, input int k);
    return (v >> k) | (v << (N - k));
  endfunction

  function automatic logic [N-1:0] bit_rev(input logic [N-1:0] v);
    logic [N-1:0] r;
    for (int b = 0; b < N; b++) r[b] = v[N-1-b];
    return r;
  endfunction

  // Apply this stage's mux levels, plus entry/exit fix-ups at the pipe ends.
  always_comb begin
    data_d = data_i;
    if (FIRST == 0 && mode_i == MODE_SHL) data_d = bit_rev(data_i);
    for (int i = FIRST; i < FIRST + COUNT; i++) begin
      if (amt_i[i]) begin
        if (mode_i == MODE_ROR) data_d = rot_r(data_d, 1 << i);
        else                    data_d = shr_fill(data_d, 1 << i, fill_i);
      end
    end
    if (LAST) begin
      if (big_i)                     data_d = {N{fill_i}};
      else if (mode_i == MODE_SHL)   data_d = bit_rev(data_d);
    end
  end

  // Payload register: frozen by EN, only overwritten by valid tokens so the output holds on bubbles.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      mode_q  <= MODE_SHL;
      fill_q  <= 1'b0;
      big_q   <= 1'b0;
    end else if (EN) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_d;
        amt_q  <= amt_i;
        mode_q <= mode_i;
        fill_q <= fill_i;
        big_q  <= big_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign amt_o   = amt_q;
  assign mode_o  = mode_q;
  assign fill_o  = fill_q;
  assign big_o   = big_q;

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined four-mode shifter (SHL/SHR/SRA/ROR) with STAGES register stages.
// Overflow and fill decisions are taken at entry and carried with the token.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int N      = 16,
  parameter int STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  shift_unit_pipe_if.slave  bus
);

  localparam int LOG2N = log2_ceil(N);

  logic             valid_s [0:STAGES];
  logic [N-1:0]     data_s  [0:STAGES];
  logic [LOG2N-1:0] amt_s   [0:STAGES];
  logic [1:0]       mode_s  [0:STAGES];
  logic             fill_s  [0:STAGES];
  logic             big_s   [0:STAGES];
  logic             unused_tail;

  assign valid_s[0] = bus.R_IN1 & bus.R_IN2;
  assign data_s[0]  = bus.D_IN1;
  assign amt_s[0]   = bus.D_IN2[LOG2N-1:0];
  assign mode_s[0]  = bus.MODE;
  assign fill_s[0]  = (bus.MODE == MODE_SRA) & bus.D_IN1[N-1];
  assign big_s[0]   = (bus.MODE != MODE_ROR) & (|bus.D_IN2[N-1:LOG2N]);

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = stage_level_lo(s, LOG2N, STAGES);
    localparam int HI = stage_level_lo(s + 1, LOG2N, STAGES);
    shift_stage #(
      .N(N), .LOG2N(LOG2N), .FIRST(LO), .COUNT(HI - LO), .LAST(s == STAGES - 1)
    ) u_stage (
      .CLK(CLK), .RST(RST), .EN(EN),
      .valid_i(valid_s[s]), .data_i(data_s[s]), .amt_i(amt_s[s]),
      .mode_i(mode_s[s]), .fill_i(fill_s[s]), .big_i(big_s[s]),
      .valid_o(valid_s[s+1]), .data_o(data_s[s+1]), .amt_o(amt_s[s+1]),
      .mode_o(mode_s[s+1]), .fill_o(fill_s[s+1]), .big_o(big_s[s+1])
    );
  end

  assign bus.R_OUT   = valid_s[STAGES];
  assign bus.D_OUT   = data_s[STAGES];
  assign bus.OVR_OUT = big_s[STAGES];

  // The last stage's routing fields have no consumer beyond the pipe.
  assign unused_tail = ^{amt_s[STAGES], mode_s[STAGES], fill_s[STAGES]};

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Bench for shift_unit_pipe: three instances (STAGES=1,2,4, N=16) share one stimulus stream
// and are compared every cycle against a delay-line model of arithmetic shift results.
module tb_shift_unit_pipe;

  localparam int DEPTH [3] = '{1, 2, 4};

  logic        clk, rst, en;
  logic        r1, r2;
  logic [15:0] d1, d2;
  logic [1:0]  md;

  shift_unit_pipe_if #(.N(16)) bus1 ();
  shift_unit_pipe_if #(.N(16)) bus2 ();
  shift_unit_pipe_if #(.N(16)) bus4 ();

  assign {bus1.R_IN1, bus1.R_IN2, bus1.D_IN1, bus1.D_IN2, bus1.MODE} = {r1, r2, d1, d2, md};
  assign {bus2.R_IN1, bus2.R_IN2, bus2.D_IN1, bus2.D_IN2, bus2.MODE} = {r1, r2, d1, d2, md};
  assign {bus4.R_IN1, bus4.R_IN2, bus4.D_IN1, bus4.D_IN2, bus4.MODE} = {r1, r2, d1, d2, md};

  shift_unit_pipe #(.N(16), .STAGES(1)) u_s1 (.CLK(clk), .RST(rst), .EN(en), .bus(bus1));
  shift_unit_pipe #(.N(16), .STAGES(2)) u_s2 (.CLK(clk), .RST(rst), .EN(en), .bus(bus2));
  shift_unit_pipe #(.N(16), .STAGES(4)) u_s4 (.CLK(clk), .RST(rst), .EN(en), .bus(bus4));

  logic        ro [3];
  logic [15:0] dout [3];
  logic        oo [3];
  assign ro[0] = bus1.R_OUT;  assign dout[0] = bus1.D_OUT;  assign oo[0] = bus1.OVR_OUT;
  assign ro[1] = bus2.R_OUT;  assign dout[1] = bus2.D_OUT;  assign oo[1] = bus2.OVR_OUT;
  assign ro[2] = bus4.R_OUT;  assign dout[2] = bus4.D_OUT;  assign oo[2] = bus4.OVR_OUT;

  // model: in-flight results per instance, plus the last delivered result
  logic        mv [3][4];
  logic [15:0] mr [3][4];
  logic        mo [3][4];
  logic [15:0] ed [3];
  logic        eo [3];

  int passed = 0;
  int total  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // {ovr, result} straight from the operator definition
  function automatic logic [16:0] ref_op(input logic [15:0] a_d, input logic [15:0] a_s,
                                         input logic [1:0] a_m);
    logic               big;
    logic signed [15:0] sd;
    logic [3:0]         rr;
    logic [15:0]        res;
    big = (a_s >= 16'd16);
    sd  = a_d;
    rr  = a_s[3:0];
    case (a_m)
      2'b00:   res = big ? 16'h0000 : (a_d << a_s);
      2'b01:   res = big ? 16'h0000 : (a_d >> a_s);
      2'b10:   res = big ? {16{a_d[15]}} : 16'(sd >>> a_s);
      default: res = (a_d >> rr) | (a_d << (5'd16 - {1'b0, rr}));
    endcase
    return {big && (a_m != 2'b11), res};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        mv[k][i] = 1'b0; mr[k][i] = '0; mo[k][i] = 1'b0;
      end
      ed[k] = '0; eo[k] = 1'b0;
    end
  endtask

  task automatic model_advance();
    logic [16:0] r;
    int          dd;
    r = ref_op(d1, d2, md);
    for (int k = 0; k < 3; k++) begin
      dd = DEPTH[k];
      for (int i = dd - 1; i > 0; i--) begin
        mv[k][i] = mv[k][i-1]; mr[k][i] = mr[k][i-1]; mo[k][i] = mo[k][i-1];
      end
      mv[k][0] = r1 && r2; mr[k][0] = r[15:0]; mo[k][0] = r[16];
      if (mv[k][dd-1]) begin
        ed[k] = mr[k][dd-1]; eo[k] = mo[k][dd-1];
      end
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("S%0d_rout", DEPTH[k]), 16'(ro[k]), 16'(mv[k][DEPTH[k]-1]));
      chk($sformatf("S%0d_dout", DEPTH[k]), dout[k], ed[k]);
      chk($sformatf("S%0d_ovr", DEPTH[k]), 16'(oo[k]), 16'(eo[k]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst && en) model_advance();
    #1;
    check_model();
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m);
    r1 = 1'b1; r2 = 1'b1; d1 = a; d2 = b; md = m;
    cycle();
  endtask

  task automatic idle();
    r1 = 1'b0; r2 = 1'b0;
    cycle();
  endtask

  task automatic expect2(input string tag, input logic r, input logic [15:0] d, input logic o);
    chk({tag, "_rout"}, 16'(ro[1]), 16'(r));
    chk({tag, "_dout"}, dout[1], d);
    chk({tag, "_ovr"}, 16'(oo[1]), 16'(o));
  endtask

  initial begin
    rst = 1'b0; en = 1'b1;
    r1 = 1'b0; r2 = 1'b0; d1 = '0; d2 = '0; md = 2'b00;
    model_clear();
    #1;
    check_model();
    cycle();
    cycle();
    rst = 1'b1;

    send(16'h8000, 16'd4, 2'b01);
    idle();
    expect2("shr_8000_4", 1'b1, 16'h0800, 1'b0);

    send(16'h8000, 16'd4, 2'b10);
    send(16'h8000, 16'd20, 2'b10);
    expect2("sra_8000_4", 1'b1, 16'hF800, 1'b0);
    idle();
    expect2("sra_8000_20", 1'b1, 16'hFFFF, 1'b1);

    send(16'h00FF, 16'd4, 2'b00);
    send(16'h00FF, 16'd16, 2'b00);
    expect2("shl_00ff_4", 1'b1, 16'h0FF0, 1'b0);
    send(16'h0001, 16'd17, 2'b11);
    expect2("shl_00ff_16", 1'b1, 16'h0000, 1'b1);
    idle();
    expect2("ror_0001_17", 1'b1, 16'h8000, 1'b0);

    send(16'hF000, 16'd0, 2'b01);
    send(16'hF000, 16'd1, 2'b01);
    expect2("stream_t1", 1'b1, 16'hF000, 1'b0);
    en = 1'b0; r1 = 1'b1; r2 = 1'b1; d1 = 16'hF000; d2 = 16'd2; md = 2'b01;
    cycle();
    expect2("freeze_a", 1'b1, 16'hF000, 1'b0);
    cycle();
    expect2("freeze_b", 1'b1, 16'hF000, 1'b0);
    en = 1'b1;
    cycle();
    expect2("stream_t2", 1'b1, 16'h7800, 1'b0);
    send(16'hF000, 16'd3, 2'b01);
    expect2("stream_t3", 1'b1, 16'h3C00, 1'b0);
    idle();
    expect2("stream_t4", 1'b1, 16'h1E00, 1'b0);
    idle();

    send(16'h1234, 16'd4, 2'b01);
    r1 = 1'b1; r2 = 1'b0;
    cycle();
    expect2("bub_pre", 1'b1, 16'h0123, 1'b0);
    send(16'hFFFF, 16'd8, 2'b01);
    expect2("bub_slot", 1'b0, 16'h0123, 1'b0);
    idle();
    expect2("bub_post", 1'b1, 16'h00FF, 1'b0);

    send(16'h1111, 16'd1, 2'b01);
    send(16'h2222, 16'd2, 2'b01);
    #3;
    rst = 1'b0;
    #1;
    model_clear();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("S%0d_rst_rout", DEPTH[k]), 16'(ro[k]), 16'h0000);
      chk($sformatf("S%0d_rst_dout", DEPTH[k]), dout[k], 16'h0000);
      chk($sformatf("S%0d_rst_ovr", DEPTH[k]), 16'(oo[k]), 16'h0000);
    end
    idle();
    rst = 1'b1;
    for (int n = 0; n < 6; n++) idle();

    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 9) != 0);
      r1 = ($urandom_range(0, 7) != 0);
      r2 = ($urandom_range(0, 7) != 0);
      d1 = 16'($urandom);
      d2 = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
      md = 2'($urandom);
      cycle();
      if ($urandom_range(0, 99) == 0) begin
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        check_model();
        cycle();
        rst = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
